// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller:
// scan state encoding and the all-segments-off pattern.
package seg7_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan_ctrl_seven_segment.sv
// Hex nibble to active-low seven-segment pattern, segments a..g on bits 6..0.
module seg7_scan_ctrl_seven_segment
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Combinational hex-to-segment lookup
    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            4'hF:    seg = 7'h38;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment display driver with dead time between digits,
// frame-synchronous display updates and optional leading-zero blanking.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int TICK_DIV = 12500,
    parameter int DEAD_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int IDX_W   = $clog2(DIGITS);
    localparam int CNT_MAX = (TICK_DIV > DEAD_CYC) ? TICK_DIV : DEAD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    state_t                state_r, state_nxt_s;
    logic [IDX_W-1:0]      idx_r, idx_nxt_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
    logic                  wrap_s;

    logic [4*DIGITS-1:0]   pend_data_r, disp_data_r;
    logic [DIGITS-1:0]     pend_dp_r, disp_dp_r;
    logic                  pend_full_r;

    logic [3:0]            nib_s;
    logic [6:0]            dec_seg_s;
    logic                  dp_bit_s;
    logic                  nz_above_s;
    logic                  blank_s;
    logic [DIGITS-1:0]     an_s;

    logic [DIGITS-1:0]     an_r;
    logic [6:0]            seg_r;
    logic                  dp_r;
    logic                  frame_done_r;

    // Scan state, digit index and shared prescaler/dead counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; wrap_s marks the last dead cycle of the last digit
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        cnt_nxt_s   = cnt_r;
        wrap_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                idx_nxt_s = {IDX_W{1'b0}};
                cnt_nxt_s = {CNT_W{1'b0}};
                if (en) begin
                    state_nxt_s = ST_SHOW;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_W'(TICK_DIV - 1)) begin
                    state_nxt_s = ST_DEAD;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DEAD: begin
                if (!en) begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == CNT_W'(DEAD_CYC - 1)) begin
                    state_nxt_s = ST_SHOW;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    if (idx_r == IDX_W'(DIGITS - 1)) begin
                        idx_nxt_s = {IDX_W{1'b0}};
                        wrap_s    = 1'b1;
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = {IDX_W{1'b0}};
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Pending/display double buffer; display only changes at a frame wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data_r <= {(4*DIGITS){1'b0}};
            pend_dp_r   <= {DIGITS{1'b0}};
            pend_full_r <= 1'b0;
            disp_data_r <= {(4*DIGITS){1'b0}};
            disp_dp_r   <= {DIGITS{1'b0}};
        end else if (wrap_s && pend_full_r) begin
            disp_data_r <= pend_data_r;
            disp_dp_r   <= pend_dp_r;
            pend_full_r <= 1'b0;
        end else if (load_valid && !pend_full_r) begin
            pend_data_r <= data_in;
            pend_dp_r   <= dp_in;
            pend_full_r <= 1'b1;
        end else begin
            pend_full_r <= pend_full_r;
        end
    end

    assign load_ready = ~pend_full_r;

    // Digit select, anode decode and leading-zero detection for the current idx
    always_comb begin
        nib_s      = 4'h0;
        dp_bit_s   = 1'b0;
        nz_above_s = 1'b0;
        an_s       = {DIGITS{1'b1}};
        for (int i = 0; i < DIGITS; i++) begin
            nib_s      = (idx_r == IDX_W'(i)) ? disp_data_r[4*i +: 4] : nib_s;
            dp_bit_s   = (idx_r == IDX_W'(i)) ? disp_dp_r[i] : dp_bit_s;
            nz_above_s = nz_above_s |
                         ((IDX_W'(i) >= idx_r) && (disp_data_r[4*i +: 4] != 4'h0));
            an_s[i]    = ~((state_r == ST_SHOW) && (idx_r == IDX_W'(i)));
        end
        blank_s = blank_lz && (idx_r != {IDX_W{1'b0}}) && !nz_above_s;
    end

    seg7_scan_ctrl_seven_segment u_dec (
        .hex (nib_s),
        .seg (dec_seg_s)
    );

    // Registered pin drivers: dark unless showing a digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r         <= {DIGITS{1'b1}};
            seg_r        <= SEG_BLANK;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= wrap_s;
            if (state_r == ST_SHOW) begin
                an_r  <= an_s;
                seg_r <= blank_s ? SEG_BLANK : dec_seg_s;
                dp_r  <= ~dp_bit_s;
            end else begin
                an_r  <= {DIGITS{1'b1}};
                seg_r <= SEG_BLANK;
                dp_r  <= 1'b1;
            end
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign dp         = dp_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with DIGITS=4, TICK_DIV=4, DEAD_CYC=2.
module tb_seg7_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load_valid;
    logic        load_ready;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int n        = 0;

    seg7_scan_ctrl #(.DIGITS(4), .TICK_DIV(4), .DEAD_CYC(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (negedge %0d)", tag, obs, exp, n);
        end
    endtask

    // Advance to negedge number t counted from the enable point
    task automatic go(input int t);
        while (n < t) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; data_in = 16'h0000; dp_in = 4'h0;
        load_valid = 1'b0; blank_lz = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_an", 16'(an), 16'h000F);
        chk("rst_seg", 16'(seg), 16'h007F);
        chk("rst_dp", 16'(dp), 16'h0001);
        chk("rst_fd", 16'(frame_done), 16'h0000);
        chk("rst_lr", 16'(load_ready), 16'h0001);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_an", 16'(an), 16'h000F);

        n = 0; en = 1'b1;
        go(2);  chk("f1d0_an", 16'(an), 16'h000E); chk("f1d0_seg", 16'(seg), 16'h0001);
                chk("f1d0_dp", 16'(dp), 16'h0001);
        go(5);  chk("f1d0_last_an", 16'(an), 16'h000E);
        go(6);  chk("f1dead_an", 16'(an), 16'h000F); chk("f1dead_seg", 16'(seg), 16'h007F);
        go(8);  chk("f1d1_an", 16'(an), 16'h000D); chk("f1d1_seg", 16'(seg), 16'h007F);
        go(14); chk("f1d2_an", 16'(an), 16'h000B); chk("f1d2_seg", 16'(seg), 16'h007F);
        go(20); chk("f1d3_an", 16'(an), 16'h0007); chk("f1d3_seg", 16'(seg), 16'h007F);
        go(24); chk("fd_pre", 16'(frame_done), 16'h0000);
        go(25); chk("fd_1", 16'(frame_done), 16'h0001);
        go(26); chk("fd_post", 16'(frame_done), 16'h0000); chk("f2d0_an", 16'(an), 16'h000E);

        go(30); chk("load1_rdy", 16'(load_ready), 16'h0001);
                load_valid = 1'b1; data_in = 16'h12AF; dp_in = 4'h0;
        go(31); chk("load1_busy", 16'(load_ready), 16'h0000); load_valid = 1'b0;
        go(32); chk("f2d1_an", 16'(an), 16'h000D); chk("f2d1_old_seg", 16'(seg), 16'h007F);
        go(40); chk("load2_blocked", 16'(load_ready), 16'h0000);
                load_valid = 1'b1; data_in = 16'h0000; dp_in = 4'b0100;
        go(44); chk("f2d3_an", 16'(an), 16'h0007); chk("f2d3_old_seg", 16'(seg), 16'h007F);
        go(48); chk("load2_still_blocked", 16'(load_ready), 16'h0000);
                chk("fd_pre2", 16'(frame_done), 16'h0000);
        go(49); chk("fd_2", 16'(frame_done), 16'h0001); chk("rdy_after_promo", 16'(load_ready), 16'h0001);
        go(50); chk("load2_taken", 16'(load_ready), 16'h0000); load_valid = 1'b0;
                chk("f3d0_an", 16'(an), 16'h000E); chk("f3d0_seg_F", 16'(seg), 16'h0038);
        go(56); chk("f3d1_an", 16'(an), 16'h000D); chk("f3d1_seg_A", 16'(seg), 16'h0008);
        go(62); chk("f3d2_an", 16'(an), 16'h000B); chk("f3d2_seg_2", 16'(seg), 16'h0012);
        go(68); chk("f3d3_an", 16'(an), 16'h0007); chk("f3d3_seg_1", 16'(seg), 16'h004F);
                chk("f3d3_dp", 16'(dp), 16'h0001);

        go(73); chk("fd_3", 16'(frame_done), 16'h0001);
        go(74); chk("f4d0_seg", 16'(seg), 16'h0001); chk("f4d0_dp", 16'(dp), 16'h0001);
        go(80); chk("f4d1_seg", 16'(seg), 16'h007F); chk("f4d1_dp", 16'(dp), 16'h0001);
        go(86); chk("f4d2_an", 16'(an), 16'h000B); chk("f4d2_seg", 16'(seg), 16'h007F);
                chk("f4d2_dp", 16'(dp), 16'h0000);

        go(89); en = 1'b0;
        go(90); chk("en_off_an", 16'(an), 16'h000F);
        go(91); chk("en_off_an2", 16'(an), 16'h000F);
        go(95); chk("idle_an2", 16'(an), 16'h000F); chk("idle_fd", 16'(frame_done), 16'h0000);
                en = 1'b1;
        go(97);  chk("re_d0_an", 16'(an), 16'h000E); chk("re_d0_seg", 16'(seg), 16'h0001);
        go(100); chk("re_d0_last_an", 16'(an), 16'h000E);
        go(101); chk("re_dead_an", 16'(an), 16'h000F);
        go(109); chk("re_d2_an", 16'(an), 16'h000B); chk("re_d2_dp", 16'(dp), 16'h0000);

        go(110); load_valid = 1'b1; data_in = 16'h5555; dp_in = 4'h0;
        go(111); chk("load3_busy", 16'(load_ready), 16'h0000); load_valid = 1'b0;
        go(115); chk("pre_rst_an", 16'(an), 16'h0007);
        go(116); rst = 1'b1;
        #1;
        chk("mid_rst_an", 16'(an), 16'h000F);
        chk("mid_rst_seg", 16'(seg), 16'h007F);
        chk("mid_rst_dp", 16'(dp), 16'h0001);
        chk("mid_rst_fd", 16'(frame_done), 16'h0000);
        chk("mid_rst_lr", 16'(load_ready), 16'h0001);
        go(117); rst = 1'b0;
        go(119); chk("post_rst_an", 16'(an), 16'h000E); chk("post_rst_seg", 16'(seg), 16'h0001);
                 chk("post_rst_lr", 16'(load_ready), 16'h0001);
        go(131); chk("post_rst_d2_dp", 16'(dp), 16'h0001); chk("post_rst_d2_seg", 16'(seg), 16'h007F);
        go(142); chk("post_rst_fd", 16'(frame_done), 16'h0001);
        go(143); chk("discarded_seg", 16'(seg), 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8, number of multiplexed digits (2..8).
REQ-002 SHALL have parameter TICK_DIV, default 12500, clk cycles each digit is lit (≥2).
REQ-003 SHALL have parameter DEAD_CYC, default 16, all-anodes-off cycles between digits (≥1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic SHALL be in this one domain.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, scan enable.
REQ-007 SHALL have port data_in, input, 4*DIGITS, hex value; nibble i drives digit i (digit 0 = LSN).
REQ-008 SHALL have port dp_in, input, DIGITS, decimal-point request per digit, active-high.
REQ-009 SHALL have port load_valid, input, 1, data_in/dp_in valid.
REQ-010 SHALL have port load_ready, output, 1, controller can accept a load.
REQ-011 SHALL have port blank_lz, input, 1, leading-zero blanking enable.
REQ-012 SHALL have port an, output, DIGITS, anode selects, active-low.
REQ-013 SHALL have port seg, output, 7, segments a..g on bits 6..0, active-low.
REQ-014 SHALL have port dp, output, 1, decimal point, active-low.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse at the end of each full scan.

Function
REQ-016 SHALL implement states IDLE, SHOW and DEAD, with a prescaler counter and a digit index idx.
REQ-017 IDLE: all anodes off; when en=1, next state SHOW with idx=0 and prescaler=0.
REQ-018 SHOW: an[idx]=0 and others 1; seg/dp from display register nibble/bit idx; after TICK_DIV cycles -> DEAD.
REQ-019 DEAD: an all 1, seg=7'h7F, dp=1 for DEAD_CYC cycles, then idx=(idx+1) mod DIGITS -> SHOW.
REQ-020 At the DEAD->SHOW transition with idx=DIGITS-1 (wrap), frame_done SHALL pulse for 1 cycle and a pending load SHALL be promoted to the display register.
REQ-021 Load handshake: capture into the pending register on load_valid && load_ready; load_ready SHALL be 0 while pending is full and 1 again the cycle after promotion.
REQ-022 A display update SHALL become visible only at a frame boundary; no frame SHALL show mixed old/new digits.
REQ-023 Leading-zero blanking with blank_lz=1: digit i>0 SHALL be dark (seg=7'h7F, an still driven) when nibbles i..DIGITS-1 are all zero; digit 0 is never blanked; dp is unaffected.
REQ-024 an, seg, dp and frame_done SHALL be registered, with 1-cycle latency from the state/idx change.
REQ-025 en falling in any state: next cycle IDLE, idx=0, prescaler=0, outputs dark; the pending and display registers are retained.
REQ-026 The prescaler SHALL count 0..TICK_DIV-1 and the dead counter 0..DEAD_CYC-1, both restarting at every state entry.

Reset
REQ-027 rst=1 SHALL force immediately: state IDLE, idx=0, counters 0, an all 1, seg=7'h7F, dp=1, frame_done=0, load_ready=1, pending empty, display register 0, dp register 0.
REQ-028 Reset asserted mid-frame or mid-handshake SHALL discard pending data; after release, behaviour is identical to power-up.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE/SHOW/DEAD) and the SEG_BLANK=7'h7F constant.
REQ-030 SHALL instantiate exactly one sub-module, the existing seven_segment decoder, fed by the idx-selected nibble; blanking is applied after the decoder.

Verification (TICK_DIV=4, DEAD_CYC=2, DIGITS=4)
REQ-031 Reset, en=1, no load -> digit 0 lit with seg for 0, digits 1..3 lit with 7'h7F when blank_lz=1; frame_done period 24 cycles.
REQ-032 Load 16'h12AF mid-frame -> load_ready drops; the current frame still shows the old value; the next frame shows F,A,2,1 on an=1110,1101,1011,0111.
REQ-033 Second load_valid while pending is full -> not accepted (load_ready=0); accepted the cycle after the frame_done promotion.
REQ-034 en deasserted during DEAD of digit 2 -> an=4'hF next cycle; re-enabled -> restart at digit 0 with a full 4-cycle SHOW.
REQ-035 rst pulsed during SHOW with a pending load -> outputs dark immediately, load_ready=1, and the display shows 0 after release.
REQ-036 dp_in=4'b0100, data 16'h0000, blank_lz=1 -> digit 2 shows dp=0 with seg 7'h7F; digit 0 shows the 0 pattern.
